// File: rtl/result_bcd_conv_pkg.sv
// ---------------------------------------------------------------------------
// volt_pkg : shared definitions for the dual-slope result readout path.
//   - state_t           : converter FSM encoding (S_IDLE / S_SHIFT / S_DONE)
//   - DEF_*             : default count width, digit count and full scale
//   - BCD_NINE          : the "9" nibble shown on overrange
//   - AVG_SAMPLES/SHIFT : averaging depth used when RESULT_AVG_EN is defined
//   - bcd_adjust()      : double-dabble digit correction (add 3 if >= 5)
// ---------------------------------------------------------------------------
package volt_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int DEF_COUNT_WIDTH = 32;
  localparam int DEF_DIGITS      = 5;
  localparam int DEF_FULL_SCALE  = 99999;

  localparam logic [3:0] BCD_NINE = 4'h9;

  localparam int AVG_SAMPLES = 4;
  localparam int AVG_SHIFT   = $clog2(AVG_SAMPLES);

  // A digit >= 5 would become >= 10 after the next doubling; pre-adding 3
  // makes the carry land in the next nibble instead.
  function automatic logic [3:0] bcd_adjust(input logic [3:0] digit);
    return (digit >= 4'd5) ? digit + 4'd3 : digit;
  endfunction

endpackage

// File: rtl/result_bcd_conv_if.sv
// ---------------------------------------------------------------------------
// result_bcd_conv_if : result capture + BCD readout bus.
//   master : conversion FSM / display side (drives the sample and ready_i)
//   slave  : result_bcd_conv (drives digits, status and valid_o)
// Signals:
//   data_ready_i, result_count_i, ref_sign_i, error_i : captured sample
//   ready_i                                           : downstream accept
//   bcd_o, sign_o, overrange_o, error_o, valid_o      : readout result
//   busy_o, overrun_o                                 : converter status
// ---------------------------------------------------------------------------
interface result_bcd_conv_if
  import volt_pkg::*;
#(
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH,
  parameter int DIGITS      = DEF_DIGITS
);

  logic                   data_ready_i;
  logic [COUNT_WIDTH-1:0] result_count_i;
  logic                   ref_sign_i;
  logic                   error_i;
  logic                   ready_i;
  logic [4*DIGITS-1:0]    bcd_o;
  logic                   sign_o;
  logic                   overrange_o;
  logic                   error_o;
  logic                   valid_o;
  logic                   busy_o;
  logic                   overrun_o;

  modport master (
    output data_ready_i, result_count_i, ref_sign_i, error_i, ready_i,
    input  bcd_o, sign_o, overrange_o, error_o, valid_o, busy_o, overrun_o
  );

  modport slave (
    input  data_ready_i, result_count_i, ref_sign_i, error_i, ready_i,
    output bcd_o, sign_o, overrange_o, error_o, valid_o, busy_o, overrun_o
  );

endinterface

// File: rtl/result_bcd_conv_bcd_add3.sv
// ---------------------------------------------------------------------------
// bcd_add3 : combinational double-dabble digit adjust.
//   digit_i : BCD digit before the shift
//   digit_o : digit_i + 3 when digit_i >= 5, otherwise digit_i
// ---------------------------------------------------------------------------
module bcd_add3
  import volt_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = bcd_adjust(digit_i);

endmodule

// File: rtl/result_bcd_conv.sv
// ---------------------------------------------------------------------------
// result_bcd_conv : captures the dual-slope FSM result and presents it as
// packed BCD over a valid/ready handshake.
//   clk_i : clock
//   rst_i : asynchronous, active-high reset
//   bus   : result_bcd_conv_if.slave (sample in, digits/status out)
// A sample accepted in S_IDLE is converted by a sequential double-dabble
// engine (one bit per cycle, COUNT_WIDTH cycles). The result is loaded in
// the first S_DONE cycle and held until ready_i. Samples arriving while
// busy or holding are dropped and flagged on the sticky overrun_o.
// Optional feature macro: RESULT_AVG_EN -- average AVG_SAMPLES same-sign
// samples and convert the truncated mean; error samples convert at once.
// ---------------------------------------------------------------------------
module result_bcd_conv
  import volt_pkg::*;
#(
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH,
  parameter int DIGITS      = DEF_DIGITS,
  parameter int FULL_SCALE  = DEF_FULL_SCALE
) (
  input logic               clk_i,
  input logic               rst_i,
  result_bcd_conv_if.slave  bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(COUNT_WIDTH + 1);
  localparam logic [COUNT_WIDTH-1:0] FS_VAL   = COUNT_WIDTH'(FULL_SCALE);
  localparam logic [CNT_W-1:0]       LAST_BIT = CNT_W'(COUNT_WIDTH - 1);

  state_t state_q, state_d;

  logic [COUNT_WIDTH-1:0] bin_q;
  logic [BCD_W-1:0]       acc_q;
  logic [BCD_W-1:0]       acc_adj;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic                   cap_sign_q;
  logic                   cap_err_q;
  logic                   cap_ovr_q;

  logic [BCD_W-1:0] bcd_q;
  logic             sign_q;
  logic             ovr_q;
  logic             err_q;
  logic             valid_q;
  logic             busy_q;
  logic             overrun_q;

  logic                   accept;
  logic                   drop;
  logic                   capture;
  logic [COUNT_WIDTH-1:0] cap_value;
  logic                   do_shift;
  logic                   do_load;
  logic                   do_release;

  assign accept = bus.data_ready_i && (state_q == S_IDLE);
  assign drop   = bus.data_ready_i && (state_q != S_IDLE);

  // -------------------------------------------------------------------------
  // Capture source: either the raw sample or the mean of a sample set.
  // -------------------------------------------------------------------------
`ifdef RESULT_AVG_EN
  logic [COUNT_WIDTH+AVG_SHIFT-1:0] sum_q;
  logic [COUNT_WIDTH+AVG_SHIFT-1:0] sum_add;
  logic [AVG_SHIFT-1:0]             avg_cnt_q;
  logic                             first_sign_q;
  logic                             set_restart;
  logic                             set_complete;

  assign sum_add      = sum_q + (COUNT_WIDTH+AVG_SHIFT)'(bus.result_count_i);
  // An empty set or a polarity change starts a fresh set with this sample.
  assign set_restart  = (avg_cnt_q == '0) || (bus.ref_sign_i != first_sign_q);
  assign set_complete = !set_restart && (avg_cnt_q == AVG_SHIFT'(AVG_SAMPLES - 1));

  always_comb begin
    capture   = 1'b0;
    cap_value = bus.result_count_i;
    if (accept) begin
      if (bus.error_i) begin
        capture = 1'b1;
      end else if (set_complete) begin
        capture   = 1'b1;
        cap_value = sum_add[COUNT_WIDTH+AVG_SHIFT-1:AVG_SHIFT];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sum_q        <= '0;
      avg_cnt_q    <= '0;
      first_sign_q <= 1'b0;
    end else if (accept) begin
      if (bus.error_i || set_complete) begin
        sum_q     <= '0;
        avg_cnt_q <= '0;
      end else if (set_restart) begin
        sum_q        <= (COUNT_WIDTH+AVG_SHIFT)'(bus.result_count_i);
        avg_cnt_q    <= AVG_SHIFT'(1);
        first_sign_q <= bus.ref_sign_i;
      end else begin
        sum_q     <= sum_add;
        avg_cnt_q <= avg_cnt_q + AVG_SHIFT'(1);
      end
    end
  end
`else
  assign capture   = accept;
  assign cap_value = bus.result_count_i;
`endif

  // -------------------------------------------------------------------------
  // Digit adjust, one instance per BCD digit.
  // -------------------------------------------------------------------------
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_add3 u_add3 (
      .digit_i (acc_q[4*g +: 4]),
      .digit_o (acc_adj[4*g +: 4])
    );
  end

  // -------------------------------------------------------------------------
  // FSM: state register + next-state / control strobes.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default before the case so that
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    do_shift   = 1'b0;
    do_load    = 1'b0;
    do_release = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (capture) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        do_shift = 1'b1;
        if (bit_cnt_q == LAST_BIT) state_d = S_DONE;
      end
      S_DONE: begin
        // First S_DONE cycle loads the outputs; afterwards wait for ready_i.
        if (!valid_q) begin
          do_load = 1'b1;
        end else if (bus.ready_i) begin
          do_release = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Conversion datapath.
  // -------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bin_q      <= '0;
      acc_q      <= '0;
      bit_cnt_q  <= '0;
      cap_sign_q <= 1'b0;
      cap_err_q  <= 1'b0;
      cap_ovr_q  <= 1'b0;
    end else if (capture) begin
      bin_q      <= cap_value;
      acc_q      <= '0;
      bit_cnt_q  <= '0;
      cap_sign_q <= bus.ref_sign_i;
      cap_err_q  <= bus.error_i;
      cap_ovr_q  <= (cap_value > FS_VAL);
    end else if (do_shift) begin
      // Bits leaving the top digit are lost; only an overrange count gets
      // that far, and its digits are replaced by nines at load time.
      acc_q     <= {acc_adj[BCD_W-2:0], bin_q[COUNT_WIDTH-1]};
      bin_q     <= {bin_q[COUNT_WIDTH-2:0], 1'b0};
      bit_cnt_q <= bit_cnt_q + CNT_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Output registers and status flags.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bcd_q     <= '0;
      sign_q    <= 1'b0;
      ovr_q     <= 1'b0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (capture) busy_q <= 1'b1;

      if (do_load) begin
        valid_q <= 1'b1;
        busy_q  <= 1'b0;
        sign_q  <= cap_sign_q;
        // Error outranks overrange.
        if (cap_err_q) begin
          bcd_q <= '0;
          err_q <= 1'b1;
          ovr_q <= 1'b0;
        end else if (cap_ovr_q) begin
          bcd_q <= {DIGITS{BCD_NINE}};
          err_q <= 1'b0;
          ovr_q <= 1'b1;
        end else begin
          bcd_q <= acc_q;
          err_q <= 1'b0;
          ovr_q <= 1'b0;
        end
      end else if (do_release) begin
        valid_q <= 1'b0;
      end

      if (accept)    overrun_q <= 1'b0;
      else if (drop) overrun_q <= 1'b1;
    end
  end

  assign bus.bcd_o       = bcd_q;
  assign bus.sign_o      = sign_q;
  assign bus.overrange_o = ovr_q;
  assign bus.error_o     = err_q;
  assign bus.valid_o     = valid_q;
  assign bus.busy_o      = busy_q;
  assign bus.overrun_o   = overrun_q;

endmodule

// File: tb/tb_result_bcd_conv.sv
// ---------------------------------------------------------------------------
// tb_result_bcd_conv : scoreboard bench for result_bcd_conv.
// Stimulus pushes the expected readout (decimal arithmetic reference) into a
// queue; an independent monitor pops it on each valid_o rise and also checks
// that the outputs stay frozen while valid_o is held.
// Honours RESULT_AVG_EN in the reference model and directed section.
// ---------------------------------------------------------------------------
module tb_result_bcd_conv;
  import volt_pkg::*;

  localparam int CW  = DEF_COUNT_WIDTH;
  localparam int DG  = DEF_DIGITS;
  localparam int FS  = DEF_FULL_SCALE;
  localparam int LAT = CW + 1;

  typedef struct {
    logic [4*DG-1:0] bcd;
    logic            sign;
    logic            ovr;
    logic            err;
    int              issue;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  result_bcd_conv_if #(.COUNT_WIDTH(CW), .DIGITS(DG)) bus ();

  result_bcd_conv #(.COUNT_WIDTH(CW), .DIGITS(DG), .FULL_SCALE(FS)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [4*DG-1:0] to_bcd(input longint unsigned v);
    logic [4*DG-1:0] r = '0;
    for (int i = 0; i < DG; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic exp_t expect_of(input longint unsigned v, input bit sign, input bit err, input int issue);
    exp_t e;
    e.sign  = sign;
    e.issue = issue;
    e.err   = err;
    e.ovr   = !err && (v > FS);
    if (err)        e.bcd = '0;
    else if (e.ovr) e.bcd = {DG{4'h9}};
    else            e.bcd = to_bcd(v);
    return e;
  endfunction

`ifdef RESULT_AVG_EN
  int              m_n = 0;
  longint unsigned m_sum = 0;
  bit              m_sign = 0;
`endif

  function automatic void model_sample(input longint unsigned v, input bit sign, input bit err, input int issue);
`ifdef RESULT_AVG_EN
    if (err) begin
      sb.push_back(expect_of(v, sign, 1'b1, issue));
      m_n = 0;
    end else if (m_n == 0 || sign != m_sign) begin
      m_sum = v; m_n = 1; m_sign = sign;
    end else begin
      m_sum += v; m_n++;
      if (m_n == AVG_SAMPLES) begin
        sb.push_back(expect_of(m_sum / AVG_SAMPLES, sign, 1'b0, issue));
        m_n = 0;
      end
    end
`else
    sb.push_back(expect_of(v, sign, err, issue));
`endif
  endfunction

  // ---------------- stimulus helpers ----------------
  // Called at posedge+#1; returns at posedge+#1 after the sampling edge.
  task automatic issue(input logic [CW-1:0] v, input bit sign, input bit err);
    bus.data_ready_i   = 1'b1;
    bus.result_count_i = v;
    bus.ref_sign_i     = sign;
    bus.error_i        = err;
    model_sample(v, sign, err, cyc + 1);
    @(posedge clk_i); #1;
    bus.data_ready_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input bit rand_ready);
    int n = 0;
    while ((bus.busy_o || bus.valid_o) && n < budget) begin
      @(posedge clk_i); #1;
      if (rand_ready) bus.ready_i = 1'($urandom % 2);
      n++;
    end
    if (n >= budget) check("wait_idle_timeout", 64'(bus.busy_o | bus.valid_o), 64'd0);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!bus.valid_o && n < budget) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (n >= budget) check("wait_valid_timeout", 64'(bus.valid_o), 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bcd"},     64'(bus.bcd_o),       64'd0);
    check({tag, "_sign"},    64'(bus.sign_o),      64'd0);
    check({tag, "_ovr"},     64'(bus.overrange_o), 64'd0);
    check({tag, "_err"},     64'(bus.error_o),     64'd0);
    check({tag, "_valid"},   64'(bus.valid_o),     64'd0);
    check({tag, "_busy"},    64'(bus.busy_o),      64'd0);
    check({tag, "_overrun"}, 64'(bus.overrun_o),   64'd0);
  endtask

  // ---------------- monitor ----------------
  logic            prev_valid = 1'b0;
  logic [4*DG+2:0] prev_data  = '0;

  always @(negedge clk_i) begin
    logic [4*DG+2:0] cur;
    exp_t e;
    cur = {bus.bcd_o, bus.sign_o, bus.overrange_o, bus.error_o};
    if (rst_i) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.valid_o && !prev_valid) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_valid: got bcd 0x%0h with no expected result (t=%0t)", bus.bcd_o, $time);
        end else begin
          e = sb.pop_front();
          check("bcd",     64'(bus.bcd_o),       64'(e.bcd));
          check("sign",    64'(bus.sign_o),      64'(e.sign));
          check("ovr",     64'(bus.overrange_o), 64'(e.ovr));
          check("err",     64'(bus.error_o),     64'(e.err));
          check("latency", 64'(cyc - e.issue),   64'(LAT));
        end
      end else if (bus.valid_o && prev_valid) begin
        check("hold_stable", 64'(cur), 64'(prev_data));
      end
      prev_valid = bus.valid_o;
      prev_data  = cur;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    logic [CW-1:0] v;
    bus.data_ready_i   = 1'b0;
    bus.result_count_i = '0;
    bus.ref_sign_i     = 1'b0;
    bus.error_i        = 1'b0;
    bus.ready_i        = 1'b0;

    #2 rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check_all_zero("reset");
    rst_i = 1'b0;
    @(posedge clk_i); #1;

`ifndef RESULT_AVG_EN
    // Basic, overrange, error priority.
    bus.ready_i = 1'b1;
    issue(CW'(12345), 1'b0, 1'b0);
    wait_idle(100, 1'b0);
    check("retain_bcd", 64'(bus.bcd_o), 64'h12345);
    issue(CW'(100000), 1'b1, 1'b0);
    wait_idle(100, 1'b0);
    issue(CW'(99999), 1'b0, 1'b0);
    wait_idle(100, 1'b0);
    issue(CW'(200000), 1'b0, 1'b1);
    wait_idle(100, 1'b0);

    // Backpressure with a dropped sample inside the hold window.
    bus.ready_i = 1'b0;
    issue(CW'(55555), 1'b0, 1'b0);
    wait_valid(100);
    for (int i = 0; i < 50; i++) begin
      bus.data_ready_i   = (i == 10);
      bus.result_count_i = CW'(1);
      @(posedge clk_i); #1;
    end
    bus.data_ready_i = 1'b0;
    check("bp_overrun", 64'(bus.overrun_o), 64'd1);
    check("bp_valid_held", 64'(bus.valid_o), 64'd1);
    bus.ready_i = 1'b1;
    @(posedge clk_i); #1;
    check("bp_valid_fall", 64'(bus.valid_o), 64'd0);
    check("bp_overrun_sticky", 64'(bus.overrun_o), 64'd1);
    issue(CW'(42), 1'b1, 1'b0);
    check("overrun_cleared", 64'(bus.overrun_o), 64'd0);
    check("busy_after_capture", 64'(bus.busy_o), 64'd1);
    wait_idle(100, 1'b0);

    // Sample dropped on the same cycle as the handshake.
    bus.ready_i = 1'b0;
    issue(CW'(8), 1'b0, 1'b0);
    wait_valid(100);
    bus.ready_i        = 1'b1;
    bus.data_ready_i   = 1'b1;
    bus.result_count_i = CW'(9);
    @(posedge clk_i); #1;
    bus.data_ready_i = 1'b0;
    check("hs_drop_valid", 64'(bus.valid_o), 64'd0);
    check("hs_drop_overrun", 64'(bus.overrun_o), 64'd1);
    check("hs_drop_idle", 64'(bus.busy_o), 64'd0);

    // Reset in the middle of a conversion.
    issue(CW'(99999), 1'b0, 1'b0);
    repeat (10) @(posedge clk_i);
    #1;
    check("mid_busy", 64'(bus.busy_o), 64'd1);
    rst_i = 1'b1;
    #1;
    check_all_zero("mid_reset");
    sb.delete();
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    issue(CW'(7), 1'b0, 1'b0);
    wait_idle(100, 1'b0);
    check("post_reset_bcd", 64'(bus.bcd_o), 64'h00007);
`else
    // Averaging: one result per four same-sign samples.
    bus.ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(CW'(100 + i), 1'b0, 1'b0);
      if (i < 3) check("avg_not_busy", 64'(bus.busy_o), 64'd0);
      wait_idle(100, 1'b0);
    end
    check("avg_bcd", 64'(bus.bcd_o), 64'h00101);
    // Sign flip on the third sample restarts the set: no output.
    issue(CW'(100), 1'b0, 1'b0);
    issue(CW'(101), 1'b0, 1'b0);
    issue(CW'(102), 1'b1, 1'b0);
    repeat (40) @(posedge clk_i);
    #1;
    check("avg_flip_no_valid", 64'(bus.valid_o), 64'd0);
`endif

    // Randomised traffic with random backpressure.
    for (int t = 0; t < 40; t++) begin
      wait_idle(400, 1'b1);
      case ($urandom % 8)
        0:       v = CW'($urandom);
        1:       v = CW'(FS + ($urandom % 2));
        2:       v = '0;
        default: v = CW'($urandom_range(0, FS));
      endcase
      issue(v, 1'($urandom % 2), ($urandom % 8) == 0);
    end

    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(posedge clk_i); #1;
      bus.ready_i = 1'($urandom % 2);
      n++;
    end
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
